// File: rtl/cpu_io_port_pkg.sv
// cpu_io_port_pkg: sequencer state codes, I/O FSM states and status bit positions
package cpu_io_port_pkg;
  localparam logic [7:0] STATE_SET_ADDR = 8'h10;
  localparam logic [7:0] STATE_OUT = 8'h11;
  localparam logic [7:0] STATE_IN = 8'h12;
  typedef enum logic {IO_FSM_IDLE, IO_FSM_ADDR} io_fsm_t;
  localparam int IO_ST_TX_NOTFULL = 0;
  localparam int IO_ST_RX_NONEMPTY = 1;
  localparam int IO_ST_RX_UDF = 2;
  localparam int IO_ST_TX_OVF = 3;
endpackage

// File: rtl/cpu_io_port_if.sv
// cpu_io_port_if: CPU bus and device TX/RX handshake signals of the I/O port
interface cpu_io_port_if;
  logic [7:0] state;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic bus_out_en;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master(output state, bus_in, tx_ready, rx_data, rx_valid,
                 input bus_out, bus_out_en, tx_data, tx_valid, rx_ready);
  modport slave(input state, bus_in, tx_ready, rx_data, rx_valid,
                output bus_out, bus_out_en, tx_data, tx_valid, rx_ready);
endinterface

// File: rtl/cpu_io_port_fifo.sv
// cpu_io_port_fifo: circular FIFO with an extra pointer MSB separating full from empty
module cpu_io_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic full,
  output logic empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  // a pop on a full FIFO frees the slot the simultaneous push lands in
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    head = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/cpu_io_port.sv
// cpu_io_port: responder for CPU IN/OUT cycles, buffering device traffic in TX/RX FIFOs
module cpu_io_port
  import cpu_io_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] DATA_PORT = 8'h00,
  parameter logic [7:0] STAT_PORT = 8'h01
) (
  input logic clk,
  input logic reset,
  cpu_io_port_if.slave io
);
  io_fsm_t fsm, fsm_nx;
  logic [7:0] addr_q, stat, rx_head;
  logic tx_ovf, rx_udf, tx_full, tx_empty, rx_full, rx_empty;
  logic rd, wr, rd_data, rd_stat, tx_push, tx_pop, ovf_set, udf_set;
  always_comb begin
    fsm_nx = io.state == STATE_SET_ADDR ? IO_FSM_ADDR : IO_FSM_IDLE;
    rd = fsm == IO_FSM_ADDR && io.state == STATE_IN;
    wr = fsm == IO_FSM_ADDR && io.state == STATE_OUT;
    rd_data = rd && addr_q == DATA_PORT;
    rd_stat = rd && addr_q == STAT_PORT;
    tx_push = wr && addr_q == DATA_PORT;
    tx_pop = io.tx_ready && !tx_empty;
    ovf_set = tx_push && tx_full && !tx_pop;
    udf_set = rd_data && rx_empty;
    stat = '0;
    stat[IO_ST_TX_OVF] = tx_ovf;
    stat[IO_ST_RX_UDF] = rx_udf;
    stat[IO_ST_RX_NONEMPTY] = !rx_empty;
    stat[IO_ST_TX_NOTFULL] = !tx_full;
    io.bus_out = rd_data ? (rx_empty ? 8'h00 : rx_head) : rd_stat ? stat : 8'h00;
    io.bus_out_en = rd;
    io.tx_valid = !tx_empty;
    io.rx_ready = !rx_full;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fsm <= IO_FSM_IDLE;
      addr_q <= '0;
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      fsm <= fsm_nx;
      if (io.state == STATE_SET_ADDR) addr_q <= io.bus_in;
      // a set landing on the clearing status read wins
      tx_ovf <= ovf_set || (tx_ovf && !rd_stat);
      rx_udf <= udf_set || (rx_udf && !rd_stat);
    end
  cpu_io_port_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .reset(reset), .push(tx_push), .pop(io.tx_ready), .din(io.bus_in),
    .full(tx_full), .empty(tx_empty), .head(io.tx_data)
  );
  cpu_io_port_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .reset(reset), .push(io.rx_valid), .pop(rd_data), .din(io.rx_data),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );
endmodule

// File: tb/tb_cpu_io_port.sv
// tb_cpu_io_port: scoreboard bench for the CPU I/O port, TX drain and read-data queues
module tb_cpu_io_port;
  import cpu_io_port_pkg::*;
  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_OTHER = 8'h55;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] got, exp;
  logic en;
  cpu_io_port_if io();
  cpu_io_port #(.FIFO_DEPTH(4), .DATA_PORT(8'h00), .STAT_PORT(8'h01)) dut (
    .clk(clk), .reset(reset), .io(io)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [7:0] st, input logic [7:0] b);
    @(negedge clk);
    io.state = st;
    io.bus_in = b;
    #1;
  endtask
  task automatic idle();
    drive(ST_IDLE, 8'h00);
  endtask
  task automatic cpu_out(input logic [7:0] a, input logic [7:0] b);
    drive(STATE_SET_ADDR, a);
    drive(STATE_OUT, b);
  endtask
  task automatic cpu_in(input logic [7:0] a, output logic [7:0] d, output logic e);
    drive(STATE_SET_ADDR, a);
    drive(STATE_IN, 8'h00);
    d = io.bus_out;
    e = io.bus_out_en;
  endtask
  task automatic test_reset();
    n_cmp++; if (io.tx_valid !== 1'b0) begin n_mis++; $display("FAIL por_tx_valid: got %b want 0", io.tx_valid); end
    n_cmp++; if (io.rx_ready !== 1'b1) begin n_mis++; $display("FAIL por_rx_ready: got %b want 1", io.rx_ready); end
    drive(STATE_SET_ADDR, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    io.state = STATE_OUT;
    io.bus_in = 8'hEE;
    #1;
    n_cmp++; if (io.tx_valid !== 1'b0) begin n_mis++; $display("FAIL rst_tx_valid: got %b want 0", io.tx_valid); end
    n_cmp++; if (io.rx_ready !== 1'b1) begin n_mis++; $display("FAIL rst_rx_ready: got %b want 1", io.rx_ready); end
    n_cmp++; if (io.bus_out_en !== 1'b0 || io.bus_out !== 8'h00) begin n_mis++; $display("FAIL rst_bus: got en=%b d=%h want en=0 d=00", io.bus_out_en, io.bus_out); end
    @(negedge clk);
    reset = 1'b0;
    idle();
    n_cmp++; if (io.tx_valid !== 1'b0) begin n_mis++; $display("FAIL rst_no_write: got tx_valid=%b want 0", io.tx_valid); end
    drive(STATE_IN, 8'h00);
    n_cmp++; if (io.bus_out_en !== 1'b0) begin n_mis++; $display("FAIL rst_fsm_idle: got en=%b want 0", io.bus_out_en); end
    idle();
  endtask
  task automatic test_single_write();
    cpu_out(8'h00, 8'hA5);
    tx_q.push_back(8'hA5);
    idle();
    n_cmp++; if (io.tx_valid !== 1'b1) begin n_mis++; $display("FAIL wr_tx_valid: got %b want 1", io.tx_valid); end
    n_cmp++; if (io.tx_data !== tx_q[0]) begin n_mis++; $display("FAIL wr_tx_data: got %h want %h", io.tx_data, tx_q[0]); end
    @(negedge clk);
    io.tx_ready = 1'b1;
    @(negedge clk);
    io.tx_ready = 1'b0;
    exp = tx_q.pop_front();
    #1;
    n_cmp++; if (io.tx_valid !== 1'b0) begin n_mis++; $display("FAIL wr_popped: got tx_valid=%b want 0 (byte %h)", io.tx_valid, exp); end
  endtask
  task automatic test_overflow();
    for (int b = 8'h11; b <= 8'h15; b++) begin
      cpu_out(8'h00, 8'(b));
      if (tx_q.size() < 4) tx_q.push_back(8'(b));
    end
    cpu_in(8'h01, got, en);
    n_cmp++; if (got !== 8'h08 || en !== 1'b1) begin n_mis++; $display("FAIL ovf_stat1: got %h en=%b want 08 en=1", got, en); end
    cpu_in(8'h01, got, en);
    n_cmp++; if (got !== 8'h00) begin n_mis++; $display("FAIL ovf_stat2: got %h want 00", got); end
    idle();
    io.tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) begin
      if (io.tx_valid) begin
        exp = tx_q.pop_front();
        n_cmp++; if (io.tx_data !== exp) begin n_mis++; $display("FAIL ovf_drain: got %h want %h", io.tx_data, exp); end
      end
      @(negedge clk);
      #1;
    end
    n_cmp++; if (tx_q.size() != 0) begin n_mis++; $display("FAIL ovf_drain_timeout: got %0d left want 0", tx_q.size()); tx_q.delete(); end
    io.tx_ready = 1'b0;
    n_cmp++; if (io.tx_valid !== 1'b0) begin n_mis++; $display("FAIL ovf_empty: got tx_valid=%b want 0", io.tx_valid); end
  endtask
  task automatic test_rx_read();
    @(negedge clk);
    io.rx_data = 8'h3C;
    io.rx_valid = 1'b1;
    @(negedge clk);
    io.rx_data = 8'h7E;
    @(negedge clk);
    io.rx_valid = 1'b0;
    rd_q.push_back(8'h3C);
    rd_q.push_back(8'h7E);
    rd_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      cpu_in(8'h00, got, en);
      exp = rd_q.pop_front();
      n_cmp++; if (got !== exp || en !== 1'b1) begin n_mis++; $display("FAIL rx_read%0d: got %h en=%b want %h en=1", i, got, en, exp); end
    end
    cpu_in(8'h01, got, en);
    n_cmp++; if (got !== 8'h05) begin n_mis++; $display("FAIL rx_udf_stat: got %h want 05", got); end
    idle();
    n_cmp++; if (io.bus_out_en !== 1'b0 || io.bus_out !== 8'h00) begin n_mis++; $display("FAIL rx_bus_idle: got en=%b d=%h want en=0 d=00", io.bus_out_en, io.bus_out); end
  endtask
  task automatic test_back_to_back();
    for (int b = 8'h21; b <= 8'h24; b++) begin
      cpu_out(8'h00, 8'(b));
      tx_q.push_back(8'(b));
    end
    drive(STATE_SET_ADDR, 8'h00);
    @(negedge clk);
    io.state = STATE_OUT;
    io.bus_in = 8'h99;
    io.tx_ready = 1'b1;
    #1;
    exp = tx_q.pop_front();
    n_cmp++; if (io.tx_data !== exp || io.tx_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_head: got %h v=%b want %h v=1", io.tx_data, io.tx_valid, exp); end
    tx_q.push_back(8'h99);
    idle();
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) begin
      if (io.tx_valid) begin
        exp = tx_q.pop_front();
        n_cmp++; if (io.tx_data !== exp) begin n_mis++; $display("FAIL b2b_drain: got %h want %h", io.tx_data, exp); end
      end
      @(negedge clk);
      #1;
    end
    n_cmp++; if (tx_q.size() != 0) begin n_mis++; $display("FAIL b2b_drain_timeout: got %0d left want 0", tx_q.size()); tx_q.delete(); end
    io.tx_ready = 1'b0;
    cpu_in(8'h01, got, en);
    n_cmp++; if (got !== 8'h01) begin n_mis++; $display("FAIL b2b_no_ovf: got %h want 01", got); end
  endtask
  task automatic test_non_io();
    drive(STATE_SET_ADDR, 8'h01);
    drive(ST_OTHER, 8'h00);
    drive(STATE_IN, 8'h00);
    n_cmp++; if (io.bus_out_en !== 1'b0 || io.bus_out !== 8'h00) begin n_mis++; $display("FAIL nio_no_read: got en=%b d=%h want en=0 d=00", io.bus_out_en, io.bus_out); end
    drive(STATE_OUT, 8'h42);
    cpu_out(8'h01, 8'hAB);
    idle();
    n_cmp++; if (io.tx_valid !== 1'b0) begin n_mis++; $display("FAIL nio_writes_ignored: got tx_valid=%b want 0", io.tx_valid); end
    drive(STATE_SET_ADDR, 8'h01);
    cpu_in(8'h05, got, en);
    n_cmp++; if (got !== 8'h00 || en !== 1'b1) begin n_mis++; $display("FAIL nio_relatch: got %h en=%b want 00 en=1", got, en); end
    idle();
  endtask
  initial begin
    io.state = ST_IDLE;
    io.bus_in = 8'h00;
    io.tx_ready = 1'b0;
    io.rx_data = 8'h00;
    io.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (io.bus_out_en !== 1'b0) begin n_mis++; $display("FAIL por_bus_en: got %b want 0", io.bus_out_en); end
    reset = 1'b0;
    test_reset();
    test_single_write();
    test_overflow();
    test_rx_read();
    test_back_to_back();
    test_non_io();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
